// File: rtl/mem_access_stage_if.sv
// EX/MEM-side data bus into the MEM stage: address, load/store strobes, store data and the
// combinational load result returned to MEM/WB.
interface mem_access_stage_if;
  logic [31:0] EX_MEM_ALUOut;
  logic        EX_MEM_MemRd;
  logic        EX_MEM_MemWr;
  logic [31:0] EX_MEM_WrData;
  logic [31:0] MemRdData;

  modport master (
    output EX_MEM_ALUOut,
    output EX_MEM_MemRd,
    output EX_MEM_MemWr,
    output EX_MEM_WrData,
    input  MemRdData
  );

  modport slave (
    input  EX_MEM_ALUOut,
    input  EX_MEM_MemRd,
    input  EX_MEM_MemWr,
    input  EX_MEM_WrData,
    output MemRdData
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: word-addressed data RAM plus a timer/systick/LED/7-seg peripheral bank,
// with a zero-latency read path and registered writes.
module mem_access_stage #(
  parameter int unsigned RAM_DEPTH = 256,
  parameter logic [31:0] MMIO_BASE = 32'h4000_0000
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_stage_if.slave   bus,
  output logic [7:0]          leds,
  output logic [11:0]         digits,
  output logic                irq
);

  localparam int unsigned IdxW = $clog2(RAM_DEPTH);

  localparam logic [2:0] RegTh      = 3'd0;
  localparam logic [2:0] RegTl      = 3'd1;
  localparam logic [2:0] RegTcon    = 3'd2;
  localparam logic [2:0] RegLed     = 3'd3;
  localparam logic [2:0] RegDigits  = 3'd4;
  localparam logic [2:0] RegSystick = 3'd5;

  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     mmio_off;
  logic [2:0]      reg_sel;
  logic [IdxW-1:0] ram_idx;
  logic            ram_hit;
  logic            mmio_hit;
  logic            wr_ram, wr_th, wr_tl, wr_tcon, wr_led, wr_digits;
  logic [31:0]     rd_word;

  logic [31:0] ram [RAM_DEPTH];

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digits_q, digits_d;
  logic [31:0] systick_q, systick_d;

  assign addr     = bus.EX_MEM_ALUOut;
  assign wdata    = bus.EX_MEM_WrData;
  assign ram_idx  = addr[IdxW+1:2];
  assign ram_hit  = (addr[31:IdxW+2] == '0);
  // Offset arithmetic keeps the decode correct for any word-aligned base.
  assign mmio_off = addr - MMIO_BASE;
  assign reg_sel  = mmio_off[4:2];
  assign mmio_hit = (mmio_off[31:5] == '0) && (reg_sel <= RegSystick);

  assign wr_ram    = bus.EX_MEM_MemWr && ram_hit;
  assign wr_th     = bus.EX_MEM_MemWr && mmio_hit && (reg_sel == RegTh);
  assign wr_tl     = bus.EX_MEM_MemWr && mmio_hit && (reg_sel == RegTl);
  assign wr_tcon   = bus.EX_MEM_MemWr && mmio_hit && (reg_sel == RegTcon);
  assign wr_led    = bus.EX_MEM_MemWr && mmio_hit && (reg_sel == RegLed);
  assign wr_digits = bus.EX_MEM_MemWr && mmio_hit && (reg_sel == RegDigits);

  // RAM is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[ram_idx] <= wdata;
    end
  end

  always_comb begin
    rd_word = '0;
    if (ram_hit) begin
      rd_word = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        RegTh:      rd_word = th_q;
        RegTl:      rd_word = tl_q;
        RegTcon:    rd_word = {29'd0, tcon_q};
        RegLed:     rd_word = {24'd0, led_q};
        RegDigits:  rd_word = {20'd0, digits_q};
        RegSystick: rd_word = systick_q;
        default:    rd_word = '0;
      endcase
    end
    bus.MemRdData = bus.EX_MEM_MemRd ? rd_word : '0;
  end

  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digits_d  = digits_q;
    systick_d = systick_q + 32'd1;

    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[1]) begin
          tcon_d[2] = 1'b1;
        end
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    // Software stores override whatever the counter did this cycle.
    if (wr_th)     th_d     = wdata;
    if (wr_tl)     tl_d     = wdata;
    if (wr_tcon)   tcon_d   = wdata[2:0];
    if (wr_led)    led_d    = wdata[7:0];
    if (wr_digits) digits_d = wdata[11:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digits_q  <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digits_q  <= digits_d;
      systick_q <= systick_d;
    end
  end

  assign leds   = led_q;
  assign digits = digits_q;
  assign irq    = tcon_q[2];

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], mmio_off[1:0]};

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected load data is queued at drive time and
// compared on the following falling edge.
module tb_mem_access_stage;

  localparam logic [31:0] Base    = 32'h4000_0000;
  localparam logic [31:0] ATh     = Base + 32'h00;
  localparam logic [31:0] ATl     = Base + 32'h04;
  localparam logic [31:0] ATcon   = Base + 32'h08;
  localparam logic [31:0] ALed    = Base + 32'h0C;
  localparam logic [31:0] ADigits = Base + 32'h10;
  localparam logic [31:0] ATick   = Base + 32'h14;
  localparam logic [31:0] AUnmap  = Base + 32'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;

  mem_access_stage_if bus ();

  mem_access_stage #(
    .RAM_DEPTH(256),
    .MMIO_BASE(Base)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .leds  (leds),
    .digits(digits),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        sb_armed = 1'b0;
  logic [31:0] tick = '0;

  // Reference free-running count: cycles since the last reset edge.
  always @(posedge clk) tick <= rst ? 32'd0 : tick + 32'd1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_armed) begin
      if (exp_q.size() == 0) check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
      else check_eq(tag_q.pop_front(), bus.MemRdData, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic [31:0] a,
                       input logic [31:0] d, input logic chk, input logic [31:0] exp,
                       input string tag);
    bus.EX_MEM_MemRd  = rd_en;
    bus.EX_MEM_MemWr  = wr_en;
    bus.EX_MEM_ALUOut = a;
    bus.EX_MEM_WrData = d;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    sb_armed = chk;
    step();
    sb_armed          = 1'b0;
    bus.EX_MEM_MemRd  = 1'b0;
    bus.EX_MEM_MemWr  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d, 1'b0, 32'd0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    drive(1'b1, 1'b0, a, 32'd0, 1'b1, exp, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.EX_MEM_ALUOut = '0;
    bus.EX_MEM_MemRd  = 1'b0;
    bus.EX_MEM_MemWr  = 1'b0;
    bus.EX_MEM_WrData = '0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    check_eq("leds_rst", 32'(leds), 32'h0);
    check_eq("digits_rst", 32'(digits), 32'h0);
    check_eq("irq_rst", 32'(irq), 32'h0);
    rd(ATh, 32'h0, "th_rst");
    rd(ATcon, 32'h0, "tcon_rst");
    rd(ATick, tick, "systick_rst");

    // RAM basics, low-bit masking, idle read, window edges
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
    rd(32'h13, 32'hDEAD_BEEF, "ram_lowbits");
    drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, "rd_disabled");
    wr(32'h0, 32'h1111_1111);
    wr(32'h3FC, 32'hCAFE_F00D);
    rd(32'h3FC, 32'hCAFE_F00D, "ram_last");
    wr(32'h400, 32'hBAD0_BAD0);
    rd(32'h400, 32'h0, "ram_oob");
    rd(32'h0, 32'h1111_1111, "ram_no_alias");

    // Same-cycle read/write returns old data
    wr(32'h4, 32'h1);
    drive(1'b1, 1'b1, 32'h4, 32'h2, 1'b1, 32'h1, "rw_old");
    rd(32'h4, 32'h2, "rw_new");

    // Timer overflow; comments give TL during the upcoming cycle
    wr(ATh, 32'hFFFF_FFFC);
    wr(ATl, 32'hFFFF_FFFE);
    wr(ATcon, 32'h3);                       // FE
    idle(1);                                // FF
    check_eq("irq_pre", 32'(irq), 32'h0);
    rd(ATl, 32'hFFFF_FFFF, "tl_max");       // FC
    check_eq("irq_ovf", 32'(irq), 32'h1);
    rd(ATl, 32'hFFFF_FFFC, "tl_reload");
    rd(ATl, 32'hFFFF_FFFD, "tl_inc");
    idle(1);
    rd(ATl, 32'hFFFF_FFFF, "tl_max2");
    rd(ATl, 32'hFFFF_FFFC, "tl_reload2");   // FD
    idle(2);                                // FF
    wr(ATl, 32'h5);
    rd(ATl, 32'h5, "tl_store_wins");
    check_eq("irq_hold", 32'(irq), 32'h1);
    wr(ATcon, 32'h3);
    check_eq("irq_clr", 32'(irq), 32'h0);
    rd(ATcon, 32'h3, "tcon_clr");
    wr(ATl, 32'hFFFF_FFFE);                 // FE
    idle(1);                                // FF
    wr(ATcon, 32'h1);
    check_eq("irq_tcon_wins", 32'(irq), 32'h0);
    rd(ATl, 32'hFFFF_FFFC, "tl_reload_tcon");
    rd(ATcon, 32'h1, "tcon_store_wins");

    // Disabled timer freezes TL
    wr(ATcon, 32'h0);
    wr(ATl, 32'd100);
    idle(3);
    rd(ATl, 32'd100, "tl_frozen");

    // Peripheral outputs and unmapped space
    wr(ALed, 32'hFFFF_FFA5);
    check_eq("leds_out", 32'(leds), 32'hA5);
    rd(ALed, 32'hA5, "led_rd");
    wr(ADigits, 32'hE3F);
    check_eq("digits_out", 32'(digits), 32'hE3F);
    rd(ADigits, 32'hE3F, "digits_rd");
    wr(AUnmap, 32'h1234_5678);
    rd(AUnmap, 32'h0, "unmapped_rd");
    check_eq("leds_keep", 32'(leds), 32'hA5);
    check_eq("digits_keep", 32'(digits), 32'hE3F);
    rd(ATh, 32'hFFFF_FFFC, "th_keep");

    // SYSTICK tracks cycles since reset and ignores stores
    rd(ATick, tick, "systick_a");
    idle(5);
    rd(ATick, tick, "systick_b");
    wr(ATick, 32'h0);
    rd(ATick, tick, "systick_ro");

    // Reset while the timer runs with irq asserted; a TL store in that cycle must lose
    wr(ATl, 32'hFFFF_FFFF);
    wr(ATcon, 32'h3);
    idle(2);
    check_eq("irq_before_rst", 32'(irq), 32'h1);
    rst = 1'b1;
    wr(ATl, 32'h77);
    rst = 1'b0;
    check_eq("irq_after_rst", 32'(irq), 32'h0);
    check_eq("leds_after_rst", 32'(leds), 32'h0);
    check_eq("digits_after_rst", 32'(digits), 32'h0);
    rd(ATl, 32'h0, "tl_after_rst");
    rd(ATcon, 32'h0, "tcon_after_rst");
    rd(32'h10, 32'hDEAD_BEEF, "ram_survives_rst");
    rd(ATick, tick, "systick_after_rst");

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage block of the 5-stage pipeline, between the EX/MEM and MEM/WB registers.
- Decodes the EX/MEM ALU result as a byte address and serves loads and stores to a word-addressed data RAM and a memory-mapped peripheral bank (timer, systick, LEDs, 7-segment digits).
- Produces the combinational MemRdData that MEM/WB latches, and raises a timer interrupt toward the control unit.

Parameters:
RAM_DEPTH, 256, number of 32-bit data RAM words; a power of 2 so the index is addr[log2(RAM_DEPTH)+1:2].
MMIO_BASE, 32'h40000000, base byte address of the peripheral bank.

Ports:
clk  input  1  pipeline clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
EX_MEM_ALUOut  input  32  byte address of the access
EX_MEM_MemRd  input  1  load enable
EX_MEM_MemWr  input  1  store enable
EX_MEM_WrData  input  32  store data (forwarded rt value)
MemRdData  output  32  load data, combinational, latched by MEM/WB
leds  output  8  LED register
digits  output  12  7-segment register: [11:8] digit anode select (active low), [7:0] segments
irq  output  1  timer interrupt request, equals TCON[2]

Behaviour:
- Interface is fixed: one clock, clk; reset rst is synchronous and active-high.
- Address bits [1:0] are ignored. Accesses are word-only.
- RAM window: addresses 0 to 4*RAM_DEPTH-1.
- MMIO window, as MMIO_BASE offsets:
  - +0x00 TH, RW
  - +0x04 TL, RW
  - +0x08 TCON, RW, bits [2:0] only
  - +0x0C LED, RW, bits [7:0]
  - +0x10 DIGITS, RW, bits [11:0]
  - +0x14 SYSTICK, RO
- Any other address is unmapped: reads return 0 and writes are dropped.
- Read path is combinational with zero cycles of latency.
  - MemRdData = selected word when EX_MEM_MemRd=1, otherwise 32'h0.
  - Narrow registers are zero-extended.
- Write path: when EX_MEM_MemWr=1 the target is updated on the next rising edge.
  - A same-cycle read of that address returns the old value. There is no write-through.
- MemRd and MemWr both high: the read returns the old value and the write is performed.
- Reset (sync):
  - TH, TL, TCON, LED, DIGITS, SYSTICK all become 0, so leds=0, digits=0, irq=0.
  - RAM contents are not cleared.
  - Reset has priority over any write or count in the same cycle.
- SYSTICK: increments by 1 every non-reset cycle and wraps 32'hFFFFFFFF to 0. Writes are ignored.
- Timer control bits:
  - TCON[0] enables counting.
  - TCON[1] enables the interrupt.
  - TCON[2] is interrupt status.
- Timer, each non-reset cycle, in priority order:
  1. A store to TL, TH or TCON takes effect. A TL store suppresses counting that cycle. A TCON store writes all 3 bits, so software clears status by writing bit 2 = 0.
  2. Otherwise, if TCON[0]=1:
     - TL==32'hFFFFFFFF: TL<=TH, and TCON[2]<=1 if TCON[1]=1.
     - Otherwise TL<=TL+1.
  - A TCON store in the same cycle as an overflow wins for TCON. TL still reloads unless TL itself is written.
- Overflow period: with TH=H, overflow repeats every (2^32-H) enabled cycles after the first reload.
- irq is a registered level, TCON[2]. It stays high until cleared by a TCON store or reset.
- Disabling the timer (TCON[0]=0) freezes TL and leaves TCON[2] unchanged.
- Reset mid-count aborts immediately. The next cycle shows TL=0 and irq=0.

Test Plan:
- RAM store/load:
  - Store 32'hDEADBEEF to 0x10, then load 0x10 the next cycle → MemRdData=32'hDEADBEEF.
  - Load 0x13 → same value (low bits ignored).
  - MemRd=0 → MemRdData=0.
- Same-cycle read/write: RAM[4] holds 32'h1. Assert MemRd and MemWr to 0x4 with 32'h2 → MemRdData=32'h1 that cycle and 32'h2 the next.
- Timer overflow:
  - Write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011.
  - TL reads FFFFFFFF one cycle after the TCON store.
  - TL becomes FFFFFFFC and irq rises 2 cycles after the TCON store.
  - Next overflow comes 4 cycles later.
  - Write TCON=3'b011 → irq=0 the next cycle.
- Priority: store TL=32'h5 in the overflow cycle → TL=5 and irq still set. Separately, a TCON store of 3'b001 in the overflow cycle → irq stays 0 and TL reloads to TH.
- MMIO outputs:
  - Store 32'hFFFFFFA5 to +0x0C → leds=8'hA5, and reading LED returns 32'hA5.
  - Store DIGITS 32'hE3F → digits=12'hE3F.
  - Store to unmapped +0x20 → no register changes, read returns 0.
- Reset and SYSTICK:
  - SYSTICK read N cycles after reset release returns N−1±0 as counted from the first post-reset edge; the bench checks that consecutive reads differ by the cycle gap.
  - Store to SYSTICK is ignored.
  - Assert rst while the timer runs with irq=1 → next cycle TL=0, TCON=0, irq=0, leds=0, and a RAM word written before reset still reads back.
